// File: rtl/riscv_checkpoint_scoreboard.sv
// riscv_checkpoint_scoreboard
//
// Watches a RISC-V core's retired-instruction count, OUTPUT_PORT and HALT.
// It checks OUTPUT_PORT against a programmable table of checkpoints. Each
// entry holds an instruction count, an expected value and a compare mask.
// The run ends in PASSED or FAILED. On failure it reports a reason code,
// the failing checkpoint index and the value seen on OUTPUT_PORT.
//
// Ports
//   CLK, RSTn        clock, synchronous active-low reset
//   CFG_WE/IDX/...   table write port, honoured only while IDLE
//   NUM_ACTIVE       number of table entries to use, sampled on START
//   START            start or restart a run (ignored while running)
//   NUM_INST,
//   OUTPUT_PORT,
//   HALT             observed core signals
//   BUSY/DONE/
//   PASS/FAIL        run status
//   REASON           0 none, 1 mismatch, 2 skipped, 3 incomplete, 4 timeout
//   FAIL_IDX/VAL     checkpoint index and OUTPUT_PORT at the failing edge
//   PASS_CNT         checkpoints passed so far
//   CYCLE            RUN cycles counted, frozen once the run ends

module riscv_checkpoint_scoreboard #(
    parameter int NUM_CHK     = 32,
    parameter int IDX_W       = 5,
    parameter int DWIDTH      = 32,
    parameter int IWIDTH      = 32,
    parameter int TIMEOUT_CYC = 100000,
    parameter int STRICT_HALT = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              CFG_WE,
    input  logic [IDX_W-1:0]  CFG_IDX,
    input  logic [IWIDTH-1:0] CFG_NUM_INST,
    input  logic [DWIDTH-1:0] CFG_ANS,
    input  logic [DWIDTH-1:0] CFG_MASK,
    input  logic [IDX_W:0]    NUM_ACTIVE,
    input  logic              START,
    input  logic [IWIDTH-1:0] NUM_INST,
    input  logic [DWIDTH-1:0] OUTPUT_PORT,
    input  logic              HALT,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic              FAIL,
    output logic [2:0]        REASON,
    output logic [IDX_W-1:0]  FAIL_IDX,
    output logic [DWIDTH-1:0] FAIL_VAL,
    output logic [IDX_W:0]    PASS_CNT,
    output logic [31:0]       CYCLE
);

    // state  | meaning
    // IDLE   | table writable, waiting for START
    // RUN    | checking NUM_INST / OUTPUT_PORT every cycle
    // PASSED | run succeeded, results held until START or reset
    // FAILED | first failure recorded, results held until START or reset
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PASSED = 2'd2,
        S_FAILED = 2'd3
    } state_t;

    localparam logic [2:0]     R_NONE       = 3'd0;
    localparam logic [2:0]     R_MISMATCH   = 3'd1;
    localparam logic [2:0]     R_SKIPPED    = 3'd2;
    localparam logic [2:0]     R_INCOMPLETE = 3'd3;
    localparam logic [2:0]     R_TIMEOUT    = 3'd4;
    localparam logic [IDX_W:0] NUM_CHK_W    = NUM_CHK[IDX_W:0];
    localparam logic [31:0]    TMR_LOAD     = TIMEOUT_CYC - 1;

    state_t state_q, state_d;

    logic [IWIDTH-1:0] tbl_num  [NUM_CHK];
    logic [DWIDTH-1:0] tbl_ans  [NUM_CHK];
    logic [DWIDTH-1:0] tbl_mask [NUM_CHK];

    logic [IDX_W:0]    ptr_q;
    logic [IDX_W:0]    active_q;
    logic [IDX_W:0]    pass_cnt_q;
    logic [31:0]       cycle_q;
    logic [31:0]       tmr_q;
    logic [2:0]        reason_q;
    logic [IDX_W-1:0]  fail_idx_q;
    logic [DWIDTH-1:0] fail_val_q;

    logic              start_run;
    logic              ptr_valid;
    logic [IDX_W-1:0]  ptr_idx;
    logic              at_chk;
    logic              chk_ok;
    logic              hit;
    logic              miss;
    logic              skipped;
    logic [IDX_W:0]    ptr_post;
    logic              halt_ok;
    logic              timeout;
    logic              run_pass;
    logic              run_fail;
    logic [2:0]        fail_reason;
    logic [IDX_W:0]    active_d;

    // Table storage carries no reset so a loaded program survives a rerun.
    always_ff @(posedge CLK) begin
        if (state_q == S_IDLE && CFG_WE && ({1'b0, CFG_IDX} < NUM_CHK_W)) begin
            tbl_num[CFG_IDX]  <= CFG_NUM_INST;
            tbl_ans[CFG_IDX]  <= CFG_ANS;
            tbl_mask[CFG_IDX] <= CFG_MASK;
        end
    end

    assign start_run = START && (state_q != S_RUN);
    assign active_d  = (NUM_ACTIVE > NUM_CHK_W) ? NUM_CHK_W : NUM_ACTIVE;

    assign ptr_idx   = ptr_q[IDX_W-1:0];
    assign ptr_valid = (ptr_q < active_q);
    assign at_chk    = ptr_valid && (NUM_INST == tbl_num[ptr_idx]);
    assign chk_ok    = (((OUTPUT_PORT ^ tbl_ans[ptr_idx]) & tbl_mask[ptr_idx]) == '0);
    assign hit       = at_chk && chk_ok;
    assign miss      = at_chk && !chk_ok;
    assign skipped   = ptr_valid && (NUM_INST > tbl_num[ptr_idx]);

    // HALT is judged against the pointer after this cycle's checkpoint hit.
    assign ptr_post  = ptr_q + {{IDX_W{1'b0}}, hit};
    assign halt_ok   = (ptr_post == active_q) || (STRICT_HALT == 0);
    // The timeout counter counts down from TIMEOUT_CYC-1, in step with CYCLE.
    assign timeout   = (tmr_q == '0);

    assign run_pass  = !miss && !skipped && HALT && halt_ok;
    assign run_fail  = miss || skipped || (HALT && !halt_ok) || (!HALT && timeout);

    always_comb begin
        fail_reason = R_TIMEOUT;
        if (miss) begin
            fail_reason = R_MISMATCH;
        end else if (skipped) begin
            fail_reason = R_SKIPPED;
        end else if (HALT) begin
            fail_reason = R_INCOMPLETE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_PASSED, S_FAILED: begin
                if (START) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (run_fail) begin
                    state_d = S_FAILED;
                end else if (run_pass) begin
                    state_d = S_PASSED;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state_q == S_RUN);
        DONE = (state_q == S_PASSED) || (state_q == S_FAILED);
        PASS = (state_q == S_PASSED);
        FAIL = (state_q == S_FAILED);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            ptr_q      <= '0;
            active_q   <= '0;
            pass_cnt_q <= '0;
            cycle_q    <= '0;
            tmr_q      <= '0;
            reason_q   <= R_NONE;
            fail_idx_q <= '0;
            fail_val_q <= '0;
        end else if (start_run) begin
            ptr_q      <= '0;
            active_q   <= active_d;
            pass_cnt_q <= '0;
            cycle_q    <= '0;
            tmr_q      <= TMR_LOAD;
            reason_q   <= R_NONE;
            fail_idx_q <= '0;
            fail_val_q <= '0;
        end else if (state_q == S_RUN) begin
            if (hit) begin
                ptr_q      <= ptr_post;
                pass_cnt_q <= pass_cnt_q + 1'b1;
            end
            if (run_fail) begin
                reason_q   <= fail_reason;
                fail_idx_q <= ptr_post[IDX_W-1:0];
                fail_val_q <= OUTPUT_PORT;
            end
            // The counters freeze on the edge that ends the run.
            if (!run_fail && !run_pass) begin
                cycle_q <= cycle_q + 32'd1;
                tmr_q   <= tmr_q - 32'd1;
            end
        end
    end

    assign REASON   = reason_q;
    assign FAIL_IDX = fail_idx_q;
    assign FAIL_VAL = fail_val_q;
    assign PASS_CNT = pass_cnt_q;
    assign CYCLE    = cycle_q;

endmodule

// File: tb/tb_riscv_checkpoint_scoreboard.sv
module tb_riscv_checkpoint_scoreboard;

    localparam int L   = 70;
    localparam int TMA = 60;
    localparam int TMB = 20;
    localparam logic [31:0] M = 32'hffff_ffff;

    logic        CLK, RSTn, CFG_WE, START, HALT;
    logic [2:0]  CFG_IDX;
    logic [31:0] CFG_NUM_INST, CFG_ANS, CFG_MASK, NUM_INST, OUTPUT_PORT;
    logic [3:0]  NUM_ACTIVE;

    logic        a_busy, a_done, a_pass, a_fail, b_busy, b_done, b_pass, b_fail;
    logic [2:0]  a_reason, b_reason, a_idx, b_idx;
    logic [31:0] a_val, b_val, a_cyc, b_cyc;
    logic [3:0]  a_cnt, b_cnt;

    riscv_checkpoint_scoreboard #(.NUM_CHK(8), .IDX_W(3), .DWIDTH(32), .IWIDTH(32),
        .TIMEOUT_CYC(TMA), .STRICT_HALT(1)) dut_a (
        .CLK(CLK), .RSTn(RSTn), .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX),
        .CFG_NUM_INST(CFG_NUM_INST), .CFG_ANS(CFG_ANS), .CFG_MASK(CFG_MASK),
        .NUM_ACTIVE(NUM_ACTIVE), .START(START), .NUM_INST(NUM_INST),
        .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT), .BUSY(a_busy), .DONE(a_done),
        .PASS(a_pass), .FAIL(a_fail), .REASON(a_reason), .FAIL_IDX(a_idx),
        .FAIL_VAL(a_val), .PASS_CNT(a_cnt), .CYCLE(a_cyc));

    riscv_checkpoint_scoreboard #(.NUM_CHK(8), .IDX_W(3), .DWIDTH(32), .IWIDTH(32),
        .TIMEOUT_CYC(TMB), .STRICT_HALT(0)) dut_b (
        .CLK(CLK), .RSTn(RSTn), .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX),
        .CFG_NUM_INST(CFG_NUM_INST), .CFG_ANS(CFG_ANS), .CFG_MASK(CFG_MASK),
        .NUM_ACTIVE(NUM_ACTIVE), .START(START), .NUM_INST(NUM_INST),
        .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT), .BUSY(b_busy), .DONE(b_done),
        .PASS(b_pass), .FAIL(b_fail), .REASON(b_reason), .FAIL_IDX(b_idx),
        .FAIL_VAL(b_val), .PASS_CNT(b_cnt), .CYCLE(b_cyc));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          pass;
        int          reason;
        int          idx;
        logic [31:0] val;
        int          cnt;
        int          cyc;
    } res_t;

    typedef struct {
        int          nact;
        logic [31:0] ans2, mask1, mask2;
        int          skip_from, cap, ov_ni;
        logic [31:0] ov_val;
        int          halt_at;
        res_t        ea, eb;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] e_num [8], e_ans [8], e_mask [8];
    int          n_wr, nact;
    logic [31:0] st_ni [L], st_out [L];
    bit          st_halt [L];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic vec_t mkv(int na, logic [31:0] a2, logic [31:0] m1, logic [31:0] m2,
                                 int skf, int cp, int ovn, logic [31:0] ovv, int ht,
                                 bit pa, int ra, int ia, logic [31:0] va, int ca, int ya,
                                 bit pb, int rb, int yb);
        vec_t v;
        v.nact = na; v.ans2 = a2; v.mask1 = m1; v.mask2 = m2;
        v.skip_from = skf; v.cap = cp; v.ov_ni = ovn; v.ov_val = ovv; v.halt_at = ht;
        v.ea = '{pa, ra, ia, va, ca, ya};
        v.eb = '{pb, rb, pb ? 0 : ia, pb ? 32'h0 : va, ca, yb};
        return v;
    endfunction

    // Default stimulus: NUM_INST counts up by one per cycle; OUTPUT_PORT
    // carries the expected answer at checkpoints and a tagged filler value otherwise.
    task automatic build_stim(input vec_t v);
        logic [31:0] ni;
        n_wr = 3; nact = v.nact;
        e_num[0] = 4; e_ans[0] = 32'h0eec; e_mask[0] = M;
        e_num[1] = 6; e_ans[1] = 32'h0;    e_mask[1] = v.mask1;
        e_num[2] = 8; e_ans[2] = v.ans2;   e_mask[2] = v.mask2;
        for (int k = 0; k < L; k++) begin
            ni = 32'(k);
            if (v.skip_from >= 0 && k > v.skip_from) ni = 32'(k + 1);
            if (v.cap >= 0 && ni > 32'(v.cap)) ni = 32'(v.cap);
            st_ni[k] = ni;
            st_out[k] = 32'hA500_0000 | ni;
            for (int e = 0; e < n_wr; e++)
                if (e_num[e] == ni) st_out[k] = e_ans[e];
            if (v.ov_ni >= 0 && ni == 32'(v.ov_ni)) st_out[k] = v.ov_val;
            st_halt[k] = (v.halt_at >= 0) && (k >= v.halt_at);
        end
    endtask

    task automatic load_and_start();
        RSTn = 1'b0; START = 1'b0; CFG_WE = 1'b0; HALT = 1'b0;
        NUM_INST = '0; OUTPUT_PORT = '0;
        repeat (2) @(posedge CLK);
        #1 RSTn = 1'b1;
        for (int e = 0; e < n_wr; e++) begin
            CFG_WE = 1'b1; CFG_IDX = 3'(e);
            CFG_NUM_INST = e_num[e]; CFG_ANS = e_ans[e]; CFG_MASK = e_mask[e];
            @(posedge CLK); #1;
        end
        CFG_WE = 1'b0;
        NUM_ACTIVE = 4'(nact); START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic drive_step(input int k);
        NUM_INST = st_ni[k]; OUTPUT_PORT = st_out[k]; HALT = st_halt[k];
        @(posedge CLK); #1;
    endtask

    // Runs the full stimulus window; every expected run ends well inside it.
    task automatic run_stim();
        load_and_start();
        for (int k = 0; k < L; k++) drive_step(k);
    endtask

    task automatic chk_res(input int id, input res_t ea, input res_t eb);
        chk($sformatf("v%0d.a_done", id),   a_done, 1);
        chk($sformatf("v%0d.a_busy", id),   a_busy, 0);
        chk($sformatf("v%0d.a_pass", id),   a_pass, ea.pass);
        chk($sformatf("v%0d.a_fail", id),   a_fail, !ea.pass);
        chk($sformatf("v%0d.a_reason", id), a_reason, ea.reason);
        chk($sformatf("v%0d.a_idx", id),    a_idx, ea.idx);
        chk($sformatf("v%0d.a_val", id),    a_val, ea.val);
        chk($sformatf("v%0d.a_cnt", id),    a_cnt, ea.cnt);
        chk($sformatf("v%0d.a_cycle", id),  a_cyc, ea.cyc);
        chk($sformatf("v%0d.b_done", id),   b_done, 1);
        chk($sformatf("v%0d.b_pass", id),   b_pass, eb.pass);
        chk($sformatf("v%0d.b_reason", id), b_reason, eb.reason);
        chk($sformatf("v%0d.b_idx", id),    b_idx, eb.idx);
        chk($sformatf("v%0d.b_val", id),    b_val, eb.val);
        chk($sformatf("v%0d.b_cnt", id),    b_cnt, eb.cnt);
        chk($sformatf("v%0d.b_cycle", id),  b_cyc, eb.cyc);
    endtask

    // Reference model: walks the checkpoint list as a queue, one step per
    // evaluated cycle, until the first terminal event.
    task automatic model(input bit strict, input int tmo, output res_t r);
        logic [31:0] qn[$], qa[$], qm[$];
        int total, consumed;
        bit term;
        total = (nact > 8) ? 8 : nact;
        for (int e = 0; e < total; e++) begin
            qn.push_back(e_num[e]); qa.push_back(e_ans[e]); qm.push_back(e_mask[e]);
        end
        r = '{0, 0, 0, 32'h0, 0, 0};
        consumed = 0;
        for (int t = 0; t < L; t++) begin
            term = 0;
            if (qn.size() > 0) begin
                if (st_ni[t] == qn[0]) begin
                    if (((st_out[t] ^ qa[0]) & qm[0]) == 0) begin
                        void'(qn.pop_front()); void'(qa.pop_front()); void'(qm.pop_front());
                        consumed++;
                    end else begin
                        term = 1; r.reason = 1;
                    end
                end else if (st_ni[t] > qn[0]) begin
                    term = 1; r.reason = 2;
                end
            end
            if (!term && st_halt[t]) begin
                term = 1;
                if (qn.size() == 0 || !strict) r.pass = 1;
                else r.reason = 3;
            end
            if (!term && t == tmo - 1) begin
                term = 1; r.reason = 4;
            end
            if (term) begin
                r.cnt = consumed;
                r.cyc = t;
                if (!r.pass) begin
                    r.idx = consumed % 8;
                    r.val = st_out[t];
                end
                break;
            end
        end
    endtask

    vec_t vt [10];

    initial begin
        res_t ra, rb;
        logic [31:0] ni;
        int r;

        vt[0] = mkv(3, 1, M, M, -1, -1, -1, 0, 9,            1, 0, 0, 0, 3, 9,              1, 0, 9);
        vt[1] = mkv(3, 1, M, M, -1, -1, 4, 32'h0eed, -1,     0, 1, 0, 32'h0eed, 0, 4,       0, 1, 4);
        vt[2] = mkv(3, 1, M, M, 5, -1, -1, 0, -1,            0, 2, 1, 32'hA500_0007, 1, 6,  0, 2, 6);
        vt[3] = mkv(3, 1, M, M, -1, -1, -1, 0, 7,            0, 3, 2, 32'hA500_0007, 2, 7,  1, 0, 7);
        vt[4] = mkv(3, 32'h0f00, M, 32'hff00, -1, -1, 8, 32'h0f5a, 8,
                                                             1, 0, 0, 0, 3, 8,              1, 0, 8);
        vt[5] = mkv(0, 1, M, M, -1, -1, -1, 0, 5,            1, 0, 0, 0, 0, 5,              1, 0, 5);
        vt[6] = mkv(3, 1, M, M, -1, 4, -1, 0, 7,             0, 3, 1, 32'h0eec, 1, 7,       1, 0, 7);
        vt[7] = mkv(3, 1, 0, M, -1, -1, 6, 32'hdeadbeef, 9,  1, 0, 0, 0, 3, 9,              1, 0, 9);
        vt[8] = mkv(3, 1, M, M, -1, -1, 8, 32'h2, 8,         0, 1, 2, 32'h2, 2, 8,          0, 1, 8);
        vt[9] = mkv(3, 1, M, M, -1, 0, -1, 0, -1,            0, 4, 0, 32'hA500_0000, 0, TMA-1, 0, 4, TMB-1);

        RSTn = 1'b0; START = 1'b0; CFG_WE = 1'b0; HALT = 1'b0; CFG_IDX = '0;
        CFG_NUM_INST = '0; CFG_ANS = '0; CFG_MASK = '0; NUM_ACTIVE = '0;
        NUM_INST = '0; OUTPUT_PORT = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset.busy", a_busy, 0);
        chk("reset.done", a_done, 0);
        chk("reset.pass_fail", {a_pass, a_fail}, 0);
        chk("reset.reason", a_reason, 0);
        chk("reset.cnt", a_cnt, 0);
        chk("reset.cycle", a_cyc, 0);
        chk("reset.fail_val", a_val, 0);

        for (int i = 0; i < 10; i++) begin
            build_stim(vt[i]);
            run_stim();
            chk_res(i, vt[i].ea, vt[i].eb);
        end

        // Restart from FAILED (the last vector timed out); table is the standard one.
        build_stim(vt[0]);
        NUM_ACTIVE = 4'd3; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        chk("restart.busy", a_busy, 1);
        chk("restart.done", a_done, 0);
        chk("restart.fail", a_fail, 0);
        chk("restart.reason", a_reason, 0);
        chk("restart.cycle", a_cyc, 0);
        chk("restart.fail_val", a_val, 0);
        chk("restart.fail_idx", a_idx, 0);
        chk("restart.cnt", a_cnt, 0);
        chk("restart.b_reason", b_reason, 0);
        // A table write and a START pulse during RUN must both be ignored.
        CFG_IDX = 3'd0; CFG_NUM_INST = 32'd1; CFG_ANS = 32'h0; CFG_MASK = M;
        for (int k = 0; k < 12; k++) begin
            CFG_WE = (k < 2);
            START = (k == 3);
            drive_step(k);
        end
        CFG_WE = 1'b0; START = 1'b0;
        chk("run_we.a_pass", a_pass, 1);
        chk("run_we.a_cnt", a_cnt, 3);
        chk("run_we.a_cycle", a_cyc, 9);
        chk("run_we.b_pass", b_pass, 1);

        // Reset in the middle of a run aborts it without DONE.
        NUM_ACTIVE = 4'd3; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int k = 3; k < 6; k++) drive_step(k);
        chk("midrst.pre_cnt", a_cnt, 1);
        chk("midrst.pre_cycle", a_cyc, 3);
        RSTn = 1'b0;
        @(posedge CLK); #1;
        chk("midrst.busy", a_busy, 0);
        chk("midrst.done", a_done, 0);
        chk("midrst.pass", a_pass, 0);
        chk("midrst.cnt", a_cnt, 0);
        chk("midrst.cycle", a_cyc, 0);
        RSTn = 1'b1;

        // NUM_ACTIVE above the table depth clamps to the depth.
        n_wr = 8; nact = 12;
        for (int e = 0; e < 8; e++) begin
            e_num[e] = 32'(2 + e); e_ans[e] = 32'(e * 3); e_mask[e] = M;
        end
        for (int k = 0; k < L; k++) begin
            st_ni[k] = 32'(k);
            st_out[k] = 32'hA500_0000 | 32'(k);
            if (k >= 2 && k <= 9) st_out[k] = 32'((k - 2) * 3);
            st_halt[k] = (k >= 12);
        end
        run_stim();
        chk_res(50, '{1, 0, 0, 32'h0, 8, 12}, '{1, 0, 0, 32'h0, 8, 12});

        // Randomised runs against the reference model.
        for (int it = 0; it < 40; it++) begin
            n_wr = 8;
            nact = $urandom_range(0, 10);
            ni = 32'($urandom_range(1, 3));
            for (int e = 0; e < 8; e++) begin
                e_num[e] = ni;
                ni = ni + 32'($urandom_range(1, 3));
                e_ans[e] = $urandom;
                r = $urandom_range(0, 3);
                e_mask[e] = (r == 0) ? 32'h0 : (r == 1) ? $urandom : M;
            end
            ni = 0;
            for (int k = 0; k < L; k++) begin
                r = $urandom_range(0, 9);
                if (k > 0) ni = ni + ((r < 3) ? 32'd0 : (r < 9) ? 32'd1 : 32'd2);
                st_ni[k] = ni;
                st_out[k] = $urandom;
                for (int e = 0; e < 8; e++)
                    if (e_num[e] == ni)
                        st_out[k] = ($urandom_range(0, 4) == 0) ?
                                    (e_ans[e] ^ (32'h1 << $urandom_range(0, 31))) : e_ans[e];
                st_halt[k] = ($urandom_range(0, 29) == 0);
            end
            model(1'b1, TMA, ra);
            model(1'b0, TMB, rb);
            run_stim();
            chk_res(100 + it, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/riscv_checkpoint_scoreboard.md
Name: riscv_checkpoint_scoreboard

Overview:
Synthesizable, parametrised scoreboard that checks the core's OUTPUT_PORT against a programmable table of (instruction-count, expected-value, mask) checkpoints. It sits beside RISCV_TOP and watches NUM_INST, OUTPUT_PORT and HALT. It reports pass/fail with a reason code, the failing index and value, and a cycle count. It adds per-checkpoint compare masks, in-order skip detection, strict-halt mode and a timeout.

Parameters:
NUM_CHK, 32, table depth (max checkpoints)
IDX_W, 5, index width, clog2(NUM_CHK)
DWIDTH, 32, OUTPUT_PORT / answer width
IWIDTH, 32, NUM_INST width
TIMEOUT_CYC, 100000, RUN cycles before timeout failure
STRICT_HALT, 1, 1: HALT before all active checkpoints pass = fail; 0: HALT = pass

Ports:
CLK  in  1  clock
RSTn  in  1  synchronous active-low reset
CFG_WE  in  1  table write strobe (honoured only in IDLE)
CFG_IDX  in  IDX_W  table entry index
CFG_NUM_INST  in  IWIDTH  instruction count at which to check
CFG_ANS  in  DWIDTH  expected value
CFG_MASK  in  DWIDTH  compare mask (1 = bit checked)
NUM_ACTIVE  in  IDX_W+1  active entry count, sampled on START
START  in  1  begin/restart run (IDLE or terminal state)
NUM_INST  in  IWIDTH  retired instruction count from core
OUTPUT_PORT  in  DWIDTH  core output port
HALT  in  1  core halt
BUSY  out  1  state == RUN
DONE  out  1  terminal state reached
PASS  out  1  run passed
FAIL  out  1  run failed
REASON  out  3  0 none, 1 mismatch, 2 skipped, 3 incomplete, 4 timeout
FAIL_IDX  out  IDX_W  checkpoint index at failure
FAIL_VAL  out  DWIDTH  OUTPUT_PORT captured at failure
PASS_CNT  out  IDX_W+1  checkpoints passed so far
CYCLE  out  32  RUN cycle count

Behaviour:
- Reset (RSTn=0 at posedge): state=IDLE. All outputs 0, ptr=0, active=0. Table contents are not reset. Reset mid-RUN aborts the run, no DONE.
- The table is written in IDLE only (CFG_WE ignored elsewhere). Entries must be in ascending CFG_NUM_INST order; the scoreboard does not sort.
- States: IDLE, RUN, PASSED, FAILED.
- IDLE/PASSED/FAILED + START -> RUN next cycle. On entry: ptr=0, PASS_CNT=0, CYCLE=0, REASON=0, FAIL_IDX=0, FAIL_VAL=0, DONE=PASS=FAIL=0, active=NUM_ACTIVE (values > NUM_CHK clamp to NUM_CHK). START while in RUN is ignored.
- RUN, evaluated each posedge with registered results (1-cycle latency). Priority order:
  1. If ptr<active and NUM_INST==num[ptr]:
     - ((OUTPUT_PORT^ans[ptr])&mask[ptr])==0 -> ptr++, PASS_CNT++.
     - Otherwise -> FAILED, REASON=1.
  2. Else if ptr<active and NUM_INST>num[ptr] -> FAILED, REASON=2.
  3. HALT=1 (evaluated with the post-increment ptr from step 1):
     - ptr==active or STRICT_HALT=0 -> PASSED.
     - Otherwise -> FAILED, REASON=3.
     - A failure already taken in step 1 or 2 wins over HALT.
  4. CYCLE==TIMEOUT_CYC-1 with no other terminal event -> FAILED, REASON=4.
- On any failure: FAIL_IDX=ptr and FAIL_VAL=OUTPUT_PORT, captured at the same edge.
- CYCLE increments every RUN cycle and freezes in terminal states.
- DONE=1 in PASSED/FAILED. PASS/FAIL mirror the state. All outputs hold until START or reset.
- active=0: only HALT or timeout can end the run; HALT -> PASSED.
- Entries with mask=0 always match at their instruction count.
- NUM_INST holding at a checkpoint value for several cycles: only the first cycle is checked, because ptr has already advanced.

Test Plan:
- Load 3 entries {4:0x0eec, 6:0x0, 8:0x1}, mask all-ones, NUM_ACTIVE=3, START. Drive matching values, then HALT at NUM_INST=9 -> PASS=1, REASON=0, PASS_CNT=3, CYCLE = number of RUN cycles.
- Same table, OUTPUT_PORT=0x0eed at NUM_INST=4 -> FAIL=1, REASON=1, FAIL_IDX=0, FAIL_VAL=0x0eed, PASS_CNT=0.
- NUM_INST jumps 5->7 (entry 6 never seen) -> FAIL, REASON=2, FAIL_IDX=1.
- HALT at NUM_INST=7 after 2 passes: STRICT_HALT=1 -> FAIL, REASON=3, PASS_CNT=2. STRICT_HALT=0 -> PASS.
- Entry {8:0x0f00, mask 0xff00} with OUTPUT_PORT=0x0f5a, HALT asserted in the same cycle -> PASS, PASS_CNT=3.
- TIMEOUT_CYC=20 with NUM_INST stuck at 0 -> FAIL, REASON=4, CYCLE=19. Then START -> RUN with all status cleared. CFG_WE pulsed during RUN leaves the table unchanged.
